rfphoenix_scratch_responder: RTL

- Memory-side responder for the core's memory request/response interface: accepts sMemoryRequest transactions, services them against a local on-chip line store, and returns one sMemoryResponse per request.
- Sits where a data cache or bus bridge would normally terminate the request channel; used as a scratchpad and as a bench target for the load/store unit.
- In-order, one outstanding access, small request FIFO in front.

---
 rtl/rfphoenix_scratch_responder.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rfphoenix_scratch_responder.sv
// Scratchpad memory responder: queues memory requests in a small FIFO and
// services them one at a time against a local store of 512-bit lines.

package rfphoenix_scratch_pkg;

  localparam logic [3:0] MR_LOAD  = 4'd0;
  localparam logic [3:0] MR_STORE = 4'd1;
  localparam logic [3:0] MR_LOADZ = 4'd7;

  localparam logic [2:0] SZ_NUL   = 3'd0;
  localparam logic [2:0] SZ_BYT   = 3'd1;
  localparam logic [2:0] SZ_WYDE  = 3'd2;
  localparam logic [2:0] SZ_TETRA = 3'd3;
  localparam logic [2:0] SZ_OCTA  = 3'd4;
  localparam logic [2:0] SZ_VECT  = 3'd5;

  localparam logic [7:0] FLT_NONE  = 8'h00;
  localparam logic [7:0] FLT_ALN   = 8'h30;
  localparam logic [7:0] FLT_UNIMP = 8'h37;
  localparam logic [7:0] FLT_PMA   = 8'h3D;

  typedef struct packed {
    logic [7:0]   tid;
    logic [7:0]   rid;
    logic [31:0]  ip;
    logic [3:0]   step;
    logic         wr;
    logic [3:0]   func;
    logic [3:0]   func2;
    logic [15:0]  asid;
    logic [2:0]   sz;
    logic [3:0]   acr;
    logic [31:0]  adr;
    logic [511:0] dat;
  } sMemoryRequest;

  typedef struct packed {
    logic          v;
    logic          empty;
    logic          cmt;
    logic [63:0]   sel;
    logic [7:0]    tid;
    logic [7:0]    rid;
    logic [31:0]   ip;
    logic [3:0]    step;
    logic          wr;
    logic [3:0]    func;
    logic [3:0]    func2;
    logic [15:0]   asid;
    logic [2:0]    sz;
    logic [3:0]    acr;
    logic [11:0]   cause;
    logic [31:0]   badAddr;
    logic [1023:0] res;
  } sMemoryResponse;

endpackage

module rfphoenix_scratch_responder
  import rfphoenix_scratch_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE       = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_v_i,
  output logic           req_rdy_o,
  input  sMemoryRequest  req_i,
  output sMemoryResponse resp_o,
  input  logic           resp_ack_i
);

  localparam int unsigned PtrW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned IdxW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] DepthLines = 32'(DEPTH);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  sMemoryRequest   fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;
  logic            fifo_full, fifo_empty;
  logic            push, pop;

  assign fifo_full  = (cnt_q == FifoFull);
  assign fifo_empty = (cnt_q == '0);
  assign req_rdy_o  = ~fifo_full;
  // Full blocks a push even if a pop frees a slot on the same edge.
  assign push       = req_v_i & ~fifo_full;

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO entry storage.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= req_i;
  end

  // ---------------------------------------------------------------------------
  // Decode and check of the held request
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  sMemoryRequest  hold_q, hold_d;
  logic [7:0]     flt_q, flt_d;
  sMemoryResponse resp_q, resp_d;

  logic [32:0] off_full;
  logic [31:0] off;
  logic        below_base;
  logic [25:0] line;
  logic [5:0]  lane;
  logic        is_store, func_ok, sz_ok, out_of_range, misaligned;
  logic [5:0]  align_mask;
  logic [63:0] be_base;
  logic [7:0]  flt;

  // Address translation, legality checks and fault priority.
  always_comb begin
    off_full   = {1'b0, hold_q.adr} - {1'b0, BASE};
    below_base = off_full[32];
    off        = off_full[31:0];
    line       = off[31:6];
    lane       = off[5:0];
    is_store   = (hold_q.func == MR_STORE);
    func_ok    = (hold_q.func == MR_LOAD) || is_store || (hold_q.func == MR_LOADZ);
    sz_ok      = 1'b1;
    align_mask = '0;
    be_base    = '0;
    case (hold_q.sz)
      SZ_BYT:   begin align_mask = 6'h00; be_base = 64'h1;  end
      SZ_WYDE:  begin align_mask = 6'h01; be_base = 64'h3;  end
      SZ_TETRA: begin align_mask = 6'h03; be_base = 64'hF;  end
      SZ_OCTA:  begin align_mask = 6'h07; be_base = 64'hFF; end
      SZ_VECT:  begin align_mask = 6'h3F; be_base = '1;     end
      default:  sz_ok = 1'b0;
    endcase
    out_of_range = below_base || ({6'd0, line} >= DepthLines);
    misaligned   = ((lane & align_mask) != '0);
    if (!func_ok || !sz_ok) begin
      flt = FLT_UNIMP;
    end else if (out_of_range) begin
      flt = FLT_PMA;
    end else if (misaligned) begin
      flt = FLT_ALN;
    end else begin
      flt = FLT_NONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Line store
  // ---------------------------------------------------------------------------
  logic [511:0]    mem [DEPTH];
  logic [511:0]    rd_q;
  logic [IdxW-1:0] mem_idx;
  logic            mem_we, mem_re;
  logic [63:0]     be;
  logic [511:0]    wdata;

  assign mem_idx = line[IdxW-1:0];
  // Only legal accesses touch the store; reset suppresses an in-flight write.
  assign mem_we  = (state_q == StAccess) && (flt == FLT_NONE) && is_store && !rst;
  assign mem_re  = (state_q == StAccess) && (flt == FLT_NONE) && !is_store && !rst;
  assign be      = be_base << lane;
  assign wdata   = hold_q.dat << {lane, 3'b000};

  // Byte-lane write and registered line read; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 64; i++) begin
        if (be[i]) mem[mem_idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (mem_re) rd_q <= mem[mem_idx];
  end

  // ---------------------------------------------------------------------------
  // Load data alignment and response assembly
  // ---------------------------------------------------------------------------
  logic [511:0]   rd_shift;
  logic [1023:0]  ld_res;
  sMemoryResponse rsp_build;

  // Right-justify the addressed bytes and extend to the returned width.
  always_comb begin
    rd_shift = rd_q >> {lane, 3'b000};
    ld_res   = '0;
    case (hold_q.sz)
      SZ_BYT: begin
        ld_res[31:0] = (hold_q.func == MR_LOADZ) ? {24'd0, rd_shift[7:0]}
                                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      SZ_WYDE: begin
        ld_res[31:0] = (hold_q.func == MR_LOADZ) ? {16'd0, rd_shift[15:0]}
                                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
      SZ_TETRA: ld_res[31:0]  = rd_shift[31:0];
      SZ_OCTA:  ld_res[63:0]  = rd_shift[63:0];
      SZ_VECT:  ld_res[511:0] = rd_shift;
      default:  ;
    endcase
  end

  // Response image built from the held request, captured fault and read data.
  always_comb begin
    rsp_build         = '0;
    rsp_build.v       = 1'b1;
    rsp_build.empty   = 1'b0;
    rsp_build.cmt     = 1'b1;
    rsp_build.sel     = '0;
    rsp_build.tid     = hold_q.tid;
    rsp_build.rid     = hold_q.rid;
    rsp_build.ip      = hold_q.ip;
    rsp_build.step    = hold_q.step;
    rsp_build.wr      = hold_q.wr;
    rsp_build.func    = hold_q.func;
    rsp_build.func2   = hold_q.func2;
    rsp_build.asid    = hold_q.asid;
    rsp_build.sz      = hold_q.sz;
    rsp_build.acr     = hold_q.acr;
    rsp_build.cause   = {4'h0, flt_q};
    rsp_build.badAddr = (flt_q != FLT_NONE) ? hold_q.adr : '0;
    rsp_build.res     = ((flt_q == FLT_NONE) && !is_store) ? ld_res : '0;
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // Next-state logic. StResp spends one cycle with v low while the read data
  // settles, then holds the response until acked. An ack with work queued
  // pops straight into StAccess so acked traffic streams at one per 3 cycles.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    flt_d   = flt_q;
    resp_d  = resp_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = fifo_mem[rd_ptr_q];
          state_d = StAccess;
        end
      end
      StAccess: begin
        flt_d   = flt;
        state_d = StResp;
      end
      StResp: begin
        if (!resp_q.v) begin
          resp_d = rsp_build;
        end else if (resp_ack_i) begin
          resp_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            hold_d  = fifo_mem[rd_ptr_q];
            state_d = StAccess;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, holding register and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
      flt_q   <= FLT_NONE;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      flt_q   <= flt_d;
      resp_q  <= resp_d;
    end
  end

  assign resp_o = resp_q;

endmodule
